// File: rtl/serial_adder_pkg.sv
// Shared state encoding and counter sizing for the serial adder.
package serial_adder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit combinational ripple adder built from single-bit full-adder cells.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_c,
    output logic [DIGIT-1:0] o_s,
    output logic             o_c
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = i_c;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_c = w_c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits of a+b+cin per clock, start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a-b via ~b and carry-in 1).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one digit summed per edge, N edges total
// DONE  | one-cycle done pulse; start here restarts immediately
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [DIGIT-1:0] w_dsum;
    logic             w_dcout;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .i_a (r_a[DIGIT-1:0]),
        .i_b (r_b[DIGIT-1:0]),
        .i_c (r_c),
        .o_s (w_dsum),
        .o_c (w_dcout)
    );

    // New digits enter at the top so the LSB digit ends up at bit 0 after N edges.
    if (N == 1) begin : g_res_single
        assign w_res_next = w_dsum;
    end else begin : g_res_shift
        assign w_res_next = {w_dsum, r_res[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_load;
                        r_c     <= w_c_load;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> DIGIT;
                    r_b   <= r_b >> DIGIT;
                    r_res <= w_res_next;
                    r_c   <= w_dcout;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_dcout;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 8-bit/1-digit and 16-bit/4-digit instances.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub8 = 1'b0;
    logic       sub16 = 1'b0;
`endif

    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    int checks = 0;
    int failures = 0;

    logic [8:0]  q8[$];
    logic [16:0] q16[$];

    serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub16),
`endif
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    // Monitors: pop the oldest expected result whenever done is seen.
    always @(negedge clk) begin
        if (done8) begin
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL sb8_unexpected_done got cout=%0b sum=%h expected no done", cout8, sum8);
            end else begin
                logic [8:0] e;
                e = q8.pop_front();
                if ({cout8, sum8} !== e) begin
                    failures++;
                    $display("FAIL sb8_result got cout=%0b sum=%h expected cout=%0b sum=%h",
                             cout8, sum8, e[8], e[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done16) begin
            checks++;
            if (q16.size() == 0) begin
                failures++;
                $display("FAIL sb16_unexpected_done got cout=%0b sum=%h expected no done", cout16, sum16);
            end else begin
                logic [16:0] e;
                e = q16.pop_front();
                if ({cout16, sum16} !== e) begin
                    failures++;
                    $display("FAIL sb16_result got cout=%0b sum=%h expected cout=%0b sum=%h",
                             cout16, sum16, e[16], e[15:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive operands, let the next edge accept them, then drop start.
    task automatic issue8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic [8:0] exp, input bit push);
        @(posedge clk); #1;
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        if (push) q8.push_back(exp);
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    // Counts from the first negedge after the accepting edge (index 1).
    task automatic wait_done8(output int idx, output int busy_cnt);
        idx = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy8) busy_cnt++;
            if (done8) begin
                idx = i;
                break;
            end
        end
    endtask

    logic [7:0] vec_a [4] = '{8'hFF, 8'h00, 8'hAA, 8'hAA};
    logic [7:0] vec_b [4] = '{8'hFF, 8'h00, 8'h55, 8'h55};
    logic       vec_c [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [8:0] vec_e [4] = '{9'h1FF, 9'h000, 9'h0FF, 9'h100};

    initial begin
        int idx, bc, dcnt;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy8", busy8, 0);
        check("reset_done8", done8, 0);
        check("reset_sum8", {cout8, sum8}, 0);
        check("reset_sum16", {cout16, sum16}, 0);

        // 1: FF + 01, carry ripples through every digit
        issue8(8'hFF, 8'h01, 1'b0, 9'h100, 1);
        wait_done8(idx, bc);
        check("t1_done_index", idx, 9);
        check("t1_busy_cycles", bc, 8);
        repeat (3) @(negedge clk);
        check("t1_sum_hold", {cout8, sum8}, 9'h100);

        // 2: 16-bit, 4-bit digits; operands disturbed mid-run
        @(posedge clk); #1;
        a16 = 16'h1234; b16 = 16'h0FCD; cin16 = 1'b1; start16 = 1'b1;
        q16.push_back(17'h02202);
        @(posedge clk); #1;
        start16 = 1'b0;
        idx = -1; bc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 2) begin
                a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b0;
                check("t2_no_partial_sum", {cout16, sum16}, 0);
            end
            if (busy16) bc++;
            if (done16) begin
                idx = i;
                break;
            end
        end
        check("t2_done_index", idx, 5);
        check("t2_busy_cycles", bc, 4);

        // 3: start during RUN is ignored
        issue8(8'd3, 8'd4, 1'b0, 9'd7, 1);
        dcnt = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 3) begin a8 = 8'd9; b8 = 8'd9; start8 = 1'b1; end
            if (i == 4) start8 = 1'b0;
            if (done8) dcnt++;
        end
        check("t3_done_pulses", dcnt, 1);

        // 4: reset mid-run discards the add and clears the result
        issue8(8'd10, 8'd20, 1'b0, 9'd0, 0);
        repeat (5) @(negedge clk);
        check("t4_busy_before_rst", busy8, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t4_rst_busy", busy8, 0);
        check("t4_rst_done", done8, 0);
        check("t4_rst_result", {cout8, sum8}, 0);
        issue8(8'd1, 8'd1, 1'b0, 9'd2, 1);
        wait_done8(idx, bc);
        check("t4_after_rst_index", idx, 9);

        // 5: back-to-back with start held through DONE
        issue8(8'h40, 8'h3F, 1'b1, 9'h080, 1);
        wait_done8(idx, bc);
        check("t5_first_index", idx, 9);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h100);
        @(posedge clk); #1;
        start8 = 1'b0;
        @(negedge clk);
        check("t5_restart_busy", busy8, 1);
        check("t5_restart_done", done8, 0);
        wait_done8(idx, bc);
        check("t5_second_index", idx, 8);
        check("t5_second_busy", bc, 7);

        // Carry-in and all-ones boundaries
        for (int v = 0; v < 4; v++) begin
            issue8(vec_a[v], vec_b[v], vec_c[v], vec_e[v], 1);
            wait_done8(idx, bc);
            check("vec_done_index", idx, 9);
        end

`ifdef SERIAL_ADDER_SUB_EN
        // 6: subtraction, borrow and no-borrow
        sub8 = 1'b1;
        issue8(8'd5, 8'd7, 1'b0, 9'h0FE, 1);
        wait_done8(idx, bc);
        check("t6_sub_index_a", idx, 9);
        issue8(8'd7, 8'd5, 1'b0, 9'h102, 1);
        wait_done8(idx, bc);
        check("t6_sub_index_b", idx, 9);
        sub8 = 1'b0;
`endif

        repeat (4) @(negedge clk);
        check("sb8_drained", q8.size(), 0);
        check("sb16_drained", q16.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
